// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//
// Multi-cycle control FSM for the 16-bit CPU datapath.  Fetches one
// instruction word per instruction over a req/ready handshake and holds it in
// the instruction register that feeds the external opcode decoder.  It then
// steps the ALU through single-cycle or multi-cycle (MUL) operations, gates
// register-file writeback, and owns the PC, the N/Z/C/V flag register and a
// saturating retired-instruction counter.
//
// Instruction timeline (zero-wait fetch, single-cycle op):
//   FETCH -> DECODE -> EXEC -> WB -> FETCH   (4 cycles per instruction)
// Each fetch wait cycle and each alu_done wait cycle adds one cycle.
//
// Handshake semantics (imem): imem_req is a Moore output that is high for
// every FETCH cycle.  imem_addr (= pc) is stable while imem_req is high.  A
// transfer happens on the rising edge where imem_req && imem_ready are both
// high; imem_rdata is captured on that edge.  imem_ready is ignored whenever
// imem_req is low.
//
// Ports:
//   clk             rising-edge clock
//   reset_n         asynchronous active-low reset
//   start           level; leaves IDLE when high
//   stop            sampled in WB; go to IDLE instead of FETCH (beats start)
//   imem_req        fetch request (high in FETCH)
//   imem_addr       fetch address, equal to pc
//   imem_ready      fetch data valid this cycle
//   imem_rdata      fetched instruction word
//   ir              instruction register, drives the decoder
//   dec_wben        decoder: op writes the register file
//   dec_setcc       decoder: op updates the condition flags
//   dec_multicycle  decoder: op completes on alu_done
//   alu_start       one-cycle pulse in the first EXEC cycle
//   alu_done        multi-cycle ALU completion
//   alu_flags       ALU N,Z,C,V result flags
//   rf_we           register-file write strobe (WB only, gated by dec_wben)
//   flags           architectural N,Z,C,V
//   pc              program counter
//   retired         retired-instruction count, saturates at 16'hFFFF
//   state           FSM state: IDLE=0 FETCH=1 DECODE=2 EXEC=3 WB=4 HALT=5
//   halted          high in HALT
// -----------------------------------------------------------------------------
module cpu_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            stop,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     ir,
    input  logic            dec_wben,
    input  logic            dec_setcc,
    input  logic            dec_multicycle,
    output logic            alu_start,
    input  logic            alu_done,
    input  logic [3:0]      alu_flags,
    output logic            rf_we,
    output logic [3:0]      flags,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     retired,
    output logic [2:0]      state,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // The all-zero instruction word is the HALT opcode.
    localparam logic [15:0] HALT_WORD = 16'h0000;

    state_t            state_q;
    state_t            state_d;
    logic              exec_first_q;
    logic [15:0]       ir_q;
    logic [PC_W-1:0]   pc_q;
    logic [3:0]        flags_q;
    logic [15:0]       retired_q;

    logic              fetch_fire;
    logic              exec_done;
    logic              exec_fire;
    logic              wb_fire;

    // A single-cycle op completes in its first EXEC cycle regardless of
    // alu_done; a multi-cycle op completes on whichever EXEC cycle sees
    // alu_done, including the first one.
    assign exec_done  = !dec_multicycle || alu_done;

    assign fetch_fire = (state_q == S_FETCH) && imem_ready;
    assign exec_fire  = (state_q == S_EXEC) && exec_done;
    assign wb_fire    = (state_q == S_WB);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (ir_q == HALT_WORD) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                // stop wins over start: the core parks in IDLE and only a
                // later start (seen in IDLE) resumes fetching.
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                // Sticky; only reset_n leaves HALT.
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and first-EXEC-cycle flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            exec_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            // Set only on the DECODE->EXEC transition so alu_start is a
            // single pulse even when EXEC lasts several cycles.
            exec_first_q <= (state_q == S_DECODE) && (state_d == S_EXEC);
        end
    end

    // ------------------------------------------------------------------
    // Instruction register and program counter: updated only on the
    // fetch handshake edge.  pc wraps modulo 2^PC_W.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q <= 16'h0000;
            pc_q <= RESET_PC;
        end else if (fetch_fire) begin
            ir_q <= imem_rdata;
            pc_q <= pc_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Condition flags: written only on the completing EXEC cycle of an op
    // that sets condition codes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= 4'b0000;
        end else if (exec_fire && dec_setcc) begin
            flags_q <= alu_flags;
        end
    end

    // ------------------------------------------------------------------
    // Retired-instruction counter: one count per WB cycle, saturating.
    // HALT never passes through WB, so it is not counted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired_q <= 16'h0000;
        end else if (wb_fire && (retired_q != 16'hFFFF)) begin
            retired_q <= retired_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs.  Strobes are decoded from the state register; rf_we is the
    // one place a decoder input reaches an output, gated by WB.
    // ------------------------------------------------------------------
    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign alu_start = (state_q == S_EXEC) && exec_first_q;
    assign rf_we     = (state_q == S_WB) && dec_wben;
    assign halted    = (state_q == S_HALT);

    assign ir        = ir_q;
    assign pc        = pc_q;
    assign flags     = flags_q;
    assign retired   = retired_q;
    assign state     = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
`timescale 1ns/1ps
module tb_cpu_sequencer;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, stop;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [15:0] ir;
    logic        dec_wben, dec_setcc, dec_multicycle;
    logic        alu_start, alu_done;
    logic [3:0]  alu_flags;
    logic        rf_we;
    logic [3:0]  flags;
    logic [7:0]  pc;
    logic [15:0] retired;
    logic [2:0]  state;
    logic        halted;

    always #5 clk = ~clk;

    cpu_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .ir(ir), .dec_wben(dec_wben),
        .dec_setcc(dec_setcc), .dec_multicycle(dec_multicycle),
        .alu_start(alu_start), .alu_done(alu_done), .alu_flags(alu_flags),
        .rf_we(rf_we), .flags(flags), .pc(pc), .retired(retired),
        .state(state), .halted(halted)
    );

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                           ST_EXEC = 3'd3, ST_WB = 3'd4, ST_HALT = 3'd5;

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    // Architectural reference model: what an instruction does to the
    // visible registers, independent of how the FSM is built.
    logic [7:0]  m_pc;
    logic [3:0]  m_flags;
    logic [15:0] m_ret;
    bit          m_idle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc = 8'h00; m_flags = 4'h0; m_ret = 16'h0000; m_idle = 1'b1;
    endtask

    task automatic randomize_dec();
        dec_wben       = 1'($urandom);
        dec_setcc      = 1'($urandom);
        dec_multicycle = 1'($urandom);
        alu_flags      = 4'($urandom);
        alu_done       = 1'($urandom);
    endtask

    // From IDLE: raise start for one edge, expect FETCH afterwards.
    task automatic kick();
        start = 1'b1;
        #1;
        chk("idle_before_start", {29'd0, state}, {29'd0, ST_IDLE});
        tick();
        start = 1'b0;
        chk("fetch_after_start", {29'd0, state}, {29'd0, ST_FETCH});
        m_idle = 1'b0;
    endtask

    // ---------------- driver + per-cycle checks ----------------
    // Precondition: called #1 after a rising edge with the DUT in FETCH.
    // The expected cycle trace is derived from the instruction parameters:
    // (fw+1) FETCH cycles, one DECODE, then (mc ? aw+1 : 1) EXEC cycles and
    // one WB, or HALT for the all-zero word.
    task automatic run_instr(input logic [15:0] word, input int fw, input bit mc,
                             input int aw, input bit setcc, input bit wben,
                             input logic [3:0] af, input bit stp);
        int n_exec;
        for (int i = 0; i <= fw; i++) begin
            imem_ready = (i == fw);
            imem_rdata = (i == fw) ? word : 16'($urandom);
            start = 1'($urandom);
            stop  = 1'($urandom);
            randomize_dec();
            #1;
            chk("fetch_state", {29'd0, state}, {29'd0, ST_FETCH});
            chk("fetch_req", {31'd0, imem_req}, 32'd1);
            chk("fetch_addr", {24'd0, imem_addr}, {24'd0, m_pc});
            chk("fetch_rf_we", {31'd0, rf_we}, 32'd0);
            tick();
        end
        m_pc = m_pc + 8'd1;

        // DECODE: stray imem_ready must not disturb ir or pc
        imem_ready     = 1'($urandom);
        imem_rdata     = 16'($urandom);
        start          = 1'b0;
        stop           = 1'b0;
        dec_wben       = wben;
        dec_setcc      = setcc;
        dec_multicycle = mc;
        alu_flags      = af;
        alu_done       = 1'($urandom);
        #1;
        chk("decode_state", {29'd0, state}, {29'd0, ST_DECODE});
        chk("decode_ir", {16'd0, ir}, {16'd0, word});
        chk("decode_pc", {24'd0, pc}, {24'd0, m_pc});
        chk("decode_req", {31'd0, imem_req}, 32'd0);
        chk("decode_alu_start", {31'd0, alu_start}, 32'd0);
        tick();

        if (word == 16'h0000) begin
            for (int k = 0; k < 4; k++) begin
                start      = 1'($urandom);
                stop       = 1'($urandom);
                imem_ready = 1'($urandom);
                randomize_dec();
                dec_setcc  = 1'b1;
                dec_wben   = 1'b1;
                #1;
                chk("halt_state", {29'd0, state}, {29'd0, ST_HALT});
                chk("halt_halted", {31'd0, halted}, 32'd1);
                chk("halt_strobes", {29'd0, imem_req, alu_start, rf_we}, 32'd0);
                chk("halt_pc", {24'd0, pc}, {24'd0, m_pc});
                chk("halt_flags", {28'd0, flags}, {28'd0, m_flags});
                chk("halt_retired", {16'd0, retired}, {16'd0, m_ret});
                tick();
            end
            start = 1'b0;
            stop  = 1'b0;
        end else begin
            n_exec = mc ? aw : 0;
            for (int j = 0; j <= n_exec; j++) begin
                alu_done   = mc ? (j == n_exec) : 1'($urandom);
                imem_ready = 1'($urandom);
                #1;
                chk("exec_state", {29'd0, state}, {29'd0, ST_EXEC});
                chk("exec_alu_start", {31'd0, alu_start}, {31'd0, (j == 0)});
                chk("exec_rf_we", {31'd0, rf_we}, 32'd0);
                chk("exec_flags", {28'd0, flags}, {28'd0, m_flags});
                tick();
            end
            if (setcc) m_flags = af;

            // WB: ALU flags wiggle here but must not be captured
            stop       = stp;
            start      = 1'($urandom);
            alu_flags  = 4'($urandom);
            alu_done   = 1'($urandom);
            imem_ready = 1'($urandom);
            #1;
            chk("wb_state", {29'd0, state}, {29'd0, ST_WB});
            chk("wb_rf_we", {31'd0, rf_we}, {31'd0, wben});
            chk("wb_alu_start", {31'd0, alu_start}, 32'd0);
            chk("wb_flags", {28'd0, flags}, {28'd0, m_flags});
            chk("wb_retired", {16'd0, retired}, {16'd0, m_ret});
            tick();
            if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
            stop  = 1'b0;
            start = 1'b0;
            chk("after_wb_state", {29'd0, state}, stp ? {29'd0, ST_IDLE} : {29'd0, ST_FETCH});
            chk("after_wb_retired", {16'd0, retired}, {16'd0, m_ret});
            chk("after_wb_flags", {28'd0, flags}, {28'd0, m_flags});
            m_idle = stp;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [15:0] word;
        int          fw;
        bit          mc;
        int          aw;
        bit          setcc;
        bit          wben;
        logic [3:0]  af;
        bit          stp;
        logic [7:0]  e_pc;
        logic [3:0]  e_flags;
        logic [15:0] e_ret;
        logic [2:0]  e_state;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h2A44, 0, 1'b0, 0, 1'b1, 1'b1, 4'b0100, 1'b0, 8'd1, 4'b0100, 16'd1, ST_FETCH};
        vecs[1] = '{16'h1234, 3, 1'b0, 0, 1'b1, 1'b0, 4'b1001, 1'b0, 8'd2, 4'b1001, 16'd2, ST_FETCH};
        vecs[2] = '{16'h5678, 0, 1'b1, 3, 1'b0, 1'b1, 4'b1111, 1'b0, 8'd3, 4'b1001, 16'd3, ST_FETCH};
        vecs[3] = '{16'h0F0F, 1, 1'b1, 0, 1'b1, 1'b1, 4'b0011, 1'b1, 8'd4, 4'b0011, 16'd4, ST_IDLE};
        vecs[4] = '{16'hFFFF, 2, 1'b0, 0, 1'b0, 1'b0, 4'b1100, 1'b0, 8'd5, 4'b0011, 16'd5, ST_FETCH};

        reset_n = 1'b0; start = 1'b0; stop = 1'b0;
        imem_ready = 1'b0; imem_rdata = 16'h0000;
        dec_wben = 1'b0; dec_setcc = 1'b0; dec_multicycle = 1'b0;
        alu_done = 1'b0; alu_flags = 4'h0;
        model_reset();
        #2;
        chk("reset_strobes", {28'd0, imem_req, alu_start, rf_we, halted}, 32'd0);
        chk("reset_state", {29'd0, state}, {29'd0, ST_IDLE});
        #20;
        reset_n = 1'b1;
        tick();

        // Idle with start low for 5 cycles
        for (int c = 0; c < 5; c++) begin
            imem_ready = 1'($urandom);
            #1;
            chk("idle_state", {29'd0, state}, {29'd0, ST_IDLE});
            chk("idle_req", {31'd0, imem_req}, 32'd0);
            chk("idle_pc", {24'd0, pc}, 32'd0);
            chk("idle_flags", {28'd0, flags}, 32'd0);
            chk("idle_retired", {16'd0, retired}, 32'd0);
            tick();
        end
        imem_ready = 1'b0;

        // Directed table
        for (int v = 0; v < 5; v++) begin
            if (m_idle) kick();
            run_instr(vecs[v].word, vecs[v].fw, vecs[v].mc, vecs[v].aw, vecs[v].setcc,
                      vecs[v].wben, vecs[v].af, vecs[v].stp);
            chk("vec_pc", {24'd0, pc}, {24'd0, vecs[v].e_pc});
            chk("vec_flags", {28'd0, flags}, {28'd0, vecs[v].e_flags});
            chk("vec_retired", {16'd0, retired}, {16'd0, vecs[v].e_ret});
            chk("vec_state", {29'd0, state}, {29'd0, vecs[v].e_state});
        end

        // Randomized instructions until the next fetch address is 8'hFF
        while (m_pc != 8'hFF) begin
            if (m_idle) kick();
            run_instr(16'($urandom_range(1, 65535)), $urandom_range(0, 3), 1'($urandom),
                      $urandom_range(0, 4), 1'($urandom), 1'($urandom), 4'($urandom),
                      ($urandom_range(0, 7) == 0));
            chk("rand_pc", {24'd0, pc}, {24'd0, m_pc});
        end

        // Fetch at 8'hFF wraps pc to 0, then HALT word at address 0
        if (m_idle) kick();
        chk("pre_wrap_addr", {24'd0, imem_addr}, 32'h0000_00FF);
        run_instr(16'h3C3C, 1, 1'b0, 0, 1'b1, 1'b1, 4'b0110, 1'b0);
        chk("pc_wrap", {24'd0, pc}, 32'd0);
        run_instr(16'h0000, 0, 1'b0, 0, 1'b0, 1'b0, 4'b0000, 1'b0);

        // Reset exits HALT
        reset_n = 1'b0;
        #1;
        chk("halt_reset_state", {29'd0, state}, {29'd0, ST_IDLE});
        chk("halt_reset_halted", {31'd0, halted}, 32'd0);
        chk("halt_reset_retired", {16'd0, retired}, 32'd0);
        #2;
        reset_n = 1'b1;
        model_reset();
        tick();
        chk("post_reset_idle", {29'd0, state}, {29'd0, ST_IDLE});

        // One instruction that sets flags, then abort a MUL mid-EXEC
        kick();
        run_instr(16'h1111, 0, 1'b0, 0, 1'b1, 1'b1, 4'b1010, 1'b0);
        chk("pre_abort_flags", {28'd0, flags}, 32'hA);
        imem_ready = 1'b1; imem_rdata = 16'h2222;
        tick();
        imem_ready = 1'b0;
        dec_multicycle = 1'b1; dec_setcc = 1'b1; dec_wben = 1'b1;
        alu_done = 1'b0; alu_flags = 4'b0101;
        tick();
        chk("abort_exec1", {30'd0, state == ST_EXEC, alu_start}, 32'd3);
        tick();
        chk("abort_exec2", {29'd0, state}, {29'd0, ST_EXEC});
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_state", {29'd0, state}, {29'd0, ST_IDLE});
        chk("abort_strobes", {29'd0, alu_start, rf_we, imem_req}, 32'd0);
        chk("abort_flags", {28'd0, flags}, 32'd0);
        chk("abort_pc", {24'd0, pc}, 32'd0);
        chk("abort_retired", {16'd0, retired}, 32'd0);
        chk("abort_ir", {16'd0, ir}, 32'd0);
        alu_done = 1'b1;
        #2;
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("abort_idle", {29'd0, state}, {29'd0, ST_IDLE});
            chk("abort_no_we", {31'd0, rf_we}, 32'd0);
            chk("abort_flags_hold", {28'd0, flags}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control FSM for the 16-bit CPU datapath. It fetches instruction words over a req/ready handshake, holds them in an instruction register that drives the combinational opcode decoder, and sequences ALU execution, including multi-cycle ops such as MUL. It also gates register-file writeback, owns the PC and the condition-flag register, and counts retired instructions. It sits between instruction memory, the opcode decoder, the ALU and the register file.

Parameters:
PC_W, 8, program counter / instruction address width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  level; leaves IDLE when high
stop  in  1  sampled in WB; returns to IDLE instead of FETCH
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address (= pc)
imem_ready  in  1  fetch data valid this cycle
imem_rdata  in  16  fetched instruction word
ir  out  16  instruction register, to decoder instr input
dec_wben  in  1  decoder writeback enable
dec_setcc  in  1  decoder set-condition-codes
dec_multicycle  in  1  decoded op needs alu_done (MUL)
alu_start  out  1  one-cycle pulse starting ALU op
alu_done  in  1  multi-cycle ALU completion
alu_flags  in  4  ALU N,Z,C,V result flags
rf_we  out  1  register-file write strobe
flags  out  4  architectural N,Z,C,V
pc  out  PC_W  program counter
retired  out  16  retired-instruction count, saturating
state  out  3  IDLE=0 FETCH=1 DECODE=2 EXEC=3 WB=4 HALT=5
halted  out  1  high in HALT

Behaviour:
- Reset (async, reset_n=0): state=IDLE, pc=RESET_PC, ir=0, flags=0, retired=0. imem_req, alu_start, rf_we and halted are 0 immediately. Reset mid-operation aborts the instruction; no write or flag update occurs.
- imem_req, alu_start, rf_we and halted are decoded from the state register (Moore), plus the EXEC first-cycle flag for alu_start. No input-to-output combinational paths except as stated below.
- IDLE: start=1 moves to FETCH next cycle; otherwise stay.
- FETCH: imem_req=1, imem_addr=pc, both stable until ready. On the cycle with imem_ready=1: ir<=imem_rdata, pc<=pc+1 modulo 2^PC_W (wraps to 0), go to DECODE. imem_ready outside FETCH is ignored.
- DECODE: one cycle; decoder settles from ir. ir==16'h0000 is HALT: go to HALT, no retire. Otherwise go to EXEC.
- EXEC: alu_start=1 in the first EXEC cycle only.
  - dec_multicycle=0: op completes in the first cycle.
  - dec_multicycle=1: stay until alu_done=1. alu_done is sampled every EXEC cycle, including the first.
  - On the completing cycle: if dec_setcc=1, flags<=alu_flags; go to WB. flags are never written in any other state.
- WB: rf_we=dec_wben for exactly one cycle. retired<=retired+1, holding at 16'hFFFF. Next state is IDLE if stop=1, else FETCH. stop takes priority over start.
- HALT: halted=1. All strobes stay 0, pc/flags/retired are frozen, start and stop are ignored. Only reset_n exits HALT.
- Throughput: single-cycle op with zero-wait fetch takes 4 cycles (FETCH, DECODE, EXEC, WB). Each fetch wait cycle adds 1; each alu_done wait cycle adds 1.
- ir, pc, flags and retired change only at the points listed above.

Test Plan:
- Reset then hold start=0 for 5 cycles -> state=0, pc=0, flags=0, retired=0, imem_req=0 throughout.
- RESET_PC=0, start=1, memory returns 16'h2A44 (ADD, setcc=1) with ready same cycle, alu_flags=4'b0100, dec_wben=1 -> imem_req one cycle, then DECODE, EXEC with alu_start pulse, then WB with rf_we=1. Result: flags=4'b0100, pc=1, retired=1, back in FETCH on cycle 5.
- imem_ready delayed 3 cycles -> imem_req held 4 cycles with imem_addr constant; pc increments once; instruction takes 7 cycles.
- dec_multicycle=1, alu_done after 4 EXEC cycles with dec_setcc=0 -> alu_start pulses once, state stays EXEC for 4 cycles, flags unchanged, single rf_we.
- PC_W=8, pc=8'hFF fetch -> pc=8'h00. Next word 16'h0000 -> HALT, halted=1, retired unchanged, start toggling has no effect; reset_n low -> IDLE.
- stop=1 during WB -> IDLE next cycle with retired incremented. Separately: reset_n pulsed low mid-EXEC (multicycle) -> state=0, no rf_we, flags cleared.
